// File: rtl/vend_controller.sv
// vend_controller: transaction sequencer for a multi-product coin vending machine.
//   It adds up coin credit and checks product selections against a programmable
//   price table. It drives the dispenser through a req/ack handshake and then pays
//   change one unit per cycle.
// Ports:
//   i_clk, i_rst          clock (rising edge) and synchronous active-high reset
//   i_in                  coin this cycle: 00 none, 01 = 1, 10 = 2, 11 = 5 units
//   o_coin_en             acceptor enable; high only in IDLE and COLLECT
//   i_sel_valid/i_sel_id  one-cycle product select strobe and product index
//   i_cancel              one-cycle refund request
//   i_sold_out            per-product stock-empty flags
//   i_cfg_we/idx/price    price table write port (price 0 disables a product)
//   o_disp_req/o_disp_id  dispense request (level) and the product being dispensed
//   i_disp_ack            dispenser done pulse
//   o_out                 vend-complete pulse
//   o_change              one pulse per change unit paid
//   o_sel_reject          select-refused pulse
//   o_credit              current credit
// All outputs are registered.
module vend_controller #(
  parameter int NUM_PROD = 4,
  parameter int SEL_W    = 2,
  parameter int CRED_W   = 8,
  parameter int TIMEOUT  = 200
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [1:0]          i_in,
  output logic                o_coin_en,
  input  logic                i_sel_valid,
  input  logic [SEL_W-1:0]    i_sel_id,
  input  logic                i_cancel,
  input  logic [NUM_PROD-1:0] i_sold_out,
  input  logic                i_cfg_we,
  input  logic [SEL_W-1:0]    i_cfg_idx,
  input  logic [CRED_W-1:0]   i_cfg_price,
  output logic                o_disp_req,
  output logic [SEL_W-1:0]    o_disp_id,
  input  logic                i_disp_ack,
  output logic                o_out,
  output logic                o_change,
  output logic                o_sel_reject,
  output logic [CRED_W-1:0]   o_credit
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_DISPENSE = 3'd2,
    S_CHANGE   = 3'd3,
    S_REFUND   = 3'd4
  } state_t;

  // Three extra bits so that credit + 5 cannot wrap before the saturation check.
  localparam logic [CRED_W+2:0] LP_CRED_MAX = {3'b000, {CRED_W{1'b1}}};
  localparam logic [15:0]       LP_TMO_LAST = 16'(TIMEOUT - 1);

  state_t              r_state;
  logic [CRED_W-1:0]   r_credit;
  logic [CRED_W-1:0]   r_price [NUM_PROD];
  logic [15:0]         r_timer;
  logic [SEL_W-1:0]    r_disp_id;
  logic [CRED_W-1:0]   r_disp_price;
  logic                r_disp_req;
  logic                r_out;
  logic                r_change;
  logic                r_sel_reject;
  logic                r_coin_en;

  logic                w_coin;
  logic [CRED_W+2:0]   w_coin_val;
  logic [CRED_W+2:0]   w_sum;
  logic [CRED_W-1:0]   w_credit_add;
  logic [CRED_W-1:0]   w_sel_price;
  logic                w_sel_sold;
  logic                w_accept;
  logic [CRED_W-1:0]   w_remain;

  // Coin decode and saturating credit add.
  always_comb begin
    w_coin = (i_in != 2'b00) && r_coin_en;
    case (i_in)
      2'b01:   w_coin_val = (CRED_W+3)'(1);
      2'b10:   w_coin_val = (CRED_W+3)'(2);
      2'b11:   w_coin_val = (CRED_W+3)'(5);
      default: w_coin_val = (CRED_W+3)'(0);
    endcase
    if (!w_coin) begin
      w_coin_val = (CRED_W+3)'(0);
    end else begin
      w_coin_val = w_coin_val;
    end
    w_sum        = {3'b000, r_credit} + w_coin_val;
    w_credit_add = (w_sum > LP_CRED_MAX) ? {CRED_W{1'b1}} : w_sum[CRED_W-1:0];
  end

  // Selection lookup. An index with no table entry reads as price 0, so it is refused.
  always_comb begin
    w_sel_price = '0;
    w_sel_sold  = 1'b0;
    for (int k = 0; k < NUM_PROD; k++) begin
      w_sel_price = (i_sel_id == SEL_W'(k)) ? r_price[k]    : w_sel_price;
      w_sel_sold  = (i_sel_id == SEL_W'(k)) ? i_sold_out[k] : w_sel_sold;
    end
    // Use the credit from before any coin in this same cycle.
    w_accept = (w_sel_price != '0) && !w_sel_sold && (r_credit >= w_sel_price);
    w_remain = r_credit - r_disp_price;
  end

  // Price table. A write is accepted in any state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_PROD; k++) r_price[k] <= '0;
    end else if (i_cfg_we) begin
      for (int k = 0; k < NUM_PROD; k++) begin
        if (i_cfg_idx == SEL_W'(k)) r_price[k] <= i_cfg_price;
      end
    end
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_credit     <= '0;
      r_timer      <= 16'd0;
      r_disp_id    <= '0;
      r_disp_price <= '0;
      r_disp_req   <= 1'b0;
      r_out        <= 1'b0;
      r_change     <= 1'b0;
      r_sel_reject <= 1'b0;
      r_coin_en    <= 1'b1;
    end else begin
      r_out        <= 1'b0;
      r_change     <= 1'b0;
      r_sel_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_coin) begin
            r_credit <= w_credit_add;
            r_timer  <= 16'd0;
            r_state  <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          // A coin is credited even when a cancel or select arrives in the same cycle.
          r_credit <= w_credit_add;
          if (i_cancel) begin
            r_state   <= S_REFUND;
            r_coin_en <= 1'b0;
          end else if (i_sel_valid) begin
            r_timer <= 16'd0;
            if (w_accept) begin
              r_disp_id    <= i_sel_id;
              r_disp_price <= w_sel_price;
              r_disp_req   <= 1'b1;
              r_coin_en    <= 1'b0;
              r_state      <= S_DISPENSE;
            end else begin
              r_sel_reject <= 1'b1;
            end
          end else if (w_coin) begin
            r_timer <= 16'd0;
          end else if (r_timer >= LP_TMO_LAST) begin
            r_state   <= S_REFUND;
            r_coin_en <= 1'b0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_DISPENSE: begin
          if (i_disp_ack) begin
            r_disp_req <= 1'b0;
            r_out      <= 1'b1;
            r_credit   <= w_remain;
            r_coin_en  <= (w_remain == '0);
            r_state    <= (w_remain != '0) ? S_CHANGE : S_IDLE;
          end
        end
        S_CHANGE, S_REFUND: begin
          if (r_credit != '0) begin
            r_change <= 1'b1;
            r_credit <= r_credit - CRED_W'(1);
          end else begin
            r_state   <= S_IDLE;
            r_coin_en <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_disp_req <= 1'b0;
          r_coin_en  <= 1'b1;
        end
      endcase
    end
  end

  assign o_coin_en    = r_coin_en;
  assign o_disp_req   = r_disp_req;
  assign o_disp_id    = r_disp_id;
  assign o_out        = r_out;
  assign o_change     = r_change;
  assign o_sel_reject = r_sel_reject;
  assign o_credit     = r_credit;

endmodule
